// File: rtl/word_sync_pkg.sv
// Shared definitions for the word synchronizer feeder: FSM state
// encoding, default timeout and a ceil-log2 helper for pointer widths.
package word_sync_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_LOW  = 2'd2,
        WAIT_HIGH = 2'd3
    } feeder_state_e;

    localparam int TO_CYCLES_DEF = 1024;

    // Smallest r with 2**r >= v.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy.
// Ports: clk, rst (async, active-high), push/push_data, pop/pop_data
// (head word, valid while !empty), level (0..DEPTH), full, empty.
module sync_fifo
    import word_sync_pkg::*;
#(
    parameter int  DWIDTH = 32,
    parameter int  DEPTH  = 4,
    localparam int AW     = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DWIDTH-1:0] push_data,
    input  logic              pop,
    output logic [DWIDTH-1:0] pop_data,
    output logic [AW:0]       level,
    output logic              full,
    output logic              empty
);

    logic [DWIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q,  level_d;

    logic push_ok;
    logic pop_ok;

    assign full     = (level_q == (AW+1)'(DEPTH));
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign pop_data = mem_q[rd_ptr_q];

    // A full FIFO refuses pushes even if it is popped in the same cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset; contents are only read while non-empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/word_sync_feeder.sv
// Source-domain feeder: buffers a valid/ready word stream and issues one
// din_en strobe per word to the word synchronizer, paced on srdy.
// Ports: clk, rst (async, active-high); in_data/in_valid/in_ready producer
// side; sync_din/sync_din_en/sync_srdy synchronizer side; level, busy,
// timeout_err (sticky) and clr_err (synchronous clear) status.
module word_sync_feeder
    import word_sync_pkg::*;
#(
    parameter int  DWIDTH    = 32,
    parameter int  DEPTH     = 4,
    parameter int  TO_CYCLES = TO_CYCLES_DEF,
    localparam int AW        = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DWIDTH-1:0] sync_din,
    output logic              sync_din_en,
    input  logic              sync_srdy,
    output logic [AW:0]       level,
    output logic              busy,
    output logic              timeout_err,
    input  logic              clr_err
);

    localparam int CW = clog2(TO_CYCLES);
    localparam logic [CW-1:0] TO_LAST = CW'(TO_CYCLES - 1);

    feeder_state_e state_q, state_d;

    logic [DWIDTH-1:0] din_q, din_d;
    logic              en_q,  en_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              err_q, err_d;

    logic              fifo_pop;
    logic [DWIDTH-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              to_hit;

    sync_fifo #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .level     (level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign in_ready    = !fifo_full;
    assign sync_din    = din_q;
    assign sync_din_en = en_q;
    assign timeout_err = err_q;
    assign busy        = (state_q != IDLE) || !fifo_empty;

    always_comb begin
        state_d  = state_q;
        din_d    = din_q;
        en_d     = 1'b0;
        cnt_d    = cnt_q;
        err_d    = err_q;
        fifo_pop = 1'b0;
        to_hit   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty && sync_srdy) begin
                    state_d  = ISSUE;
                    din_d    = fifo_head;
                    en_d     = 1'b1;
                    fifo_pop = 1'b1;
                end
            end
            ISSUE: begin
                state_d = WAIT_LOW;
                cnt_d   = '0;
            end
            WAIT_LOW: begin
                // Seeing srdy drop is progress and beats a same-cycle timeout.
                if (!sync_srdy) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    to_hit = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_HIGH: begin
                if (sync_srdy) begin
                    state_d = IDLE;
                end else if (cnt_q == TO_LAST) begin
                    to_hit = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase

        // A stalled handshake abandons the word; buffered words stay queued.
        if (to_hit) begin
            state_d = IDLE;
            cnt_d   = '0;
        end

        if (to_hit) begin
            err_d = 1'b1;
        end else if (clr_err) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            din_q   <= '0;
            en_q    <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            din_q   <= din_d;
            en_q    <= en_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_word_sync_feeder.sv
// Self-checking bench for word_sync_feeder: a queue-based reference of
// the feeder compared every cycle, plus directed literal expectations.
module tb_word_sync_feeder;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int TO    = 16;
    localparam int AW    = 2;
    localparam int RT    = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] sync_din;
    logic          sync_din_en;
    logic          sync_srdy = 1'b1;
    logic [AW:0]   level;
    logic          busy;
    logic          timeout_err;
    logic          clr_err = 1'b0;

    always #5 clk = ~clk;

    word_sync_feeder #(
        .DWIDTH    (DW),
        .DEPTH     (DEPTH),
        .TO_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .sync_din    (sync_din),
        .sync_din_en (sync_din_en),
        .sync_srdy   (sync_srdy),
        .level       (level),
        .busy        (busy),
        .timeout_err (timeout_err),
        .clr_err     (clr_err)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    // Reference: words waiting, handshake phase (0 free, 1 await srdy low,
    // 2 await srdy high), phase entry time, expected strobe/data/error.
    logic [DW-1:0] mq[$];
    int            m_hs = 0;
    int            m_t = 0;
    int            m_phase_t = 0;
    logic          m_strobe = 1'b0;
    logic [DW-1:0] m_din = '0;
    logic          m_err = 1'b0;
    bit            m_push;
    bit            m_tmo;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_hs = 0;
            m_t = 0;
            m_phase_t = 0;
            m_strobe = 1'b0;
            m_din = '0;
            m_err = 1'b0;
        end else begin
            m_t++;
            m_push = in_valid && (mq.size() != DEPTH);
            m_tmo = 1'b0;
            if (m_strobe) begin
                m_strobe = 1'b0;
                m_hs = 1;
                m_phase_t = m_t;
            end else if (m_hs == 1) begin
                if (!sync_srdy) begin
                    m_hs = 2;
                    m_phase_t = m_t;
                end else if (m_t - m_phase_t == TO) begin
                    m_hs = 0;
                    m_tmo = 1'b1;
                end
            end else if (m_hs == 2) begin
                if (sync_srdy) m_hs = 0;
                else if (m_t - m_phase_t == TO) begin
                    m_hs = 0;
                    m_tmo = 1'b1;
                end
            end else if (mq.size() != 0 && sync_srdy) begin
                m_din = mq.pop_front();
                m_strobe = 1'b1;
            end
            if (m_push) mq.push_back(in_data);
            if (m_tmo) m_err = 1'b1;
            else if (clr_err) m_err = 1'b0;
        end
    end

    // Synchronizer stand-in: drops srdy after sampling a strobe, raises it
    // again RT cycles later.
    bit   hs_auto = 1'b1;
    int   rt = 0;
    logic en_neg = 1'b0;

    always @(negedge clk) en_neg = sync_din_en;

    always @(posedge clk) begin
        if (hs_auto && !rst) begin
            #1;
            if (en_neg) begin
                sync_srdy = 1'b0;
                rt = RT;
            end else if (rt > 0) begin
                rt--;
                if (rt == 0) sync_srdy = 1'b1;
            end
        end
    end

    bit            chk_on = 1'b0;
    int            cyc = 0;
    logic [DW-1:0] seen[$];
    int            st[$];

    always @(negedge clk) begin
        cyc++;
        if (chk_on) begin
            chk("cyc_en", sync_din_en, m_strobe);
            chk("cyc_din", sync_din, m_din);
            chk("cyc_level", level, mq.size());
            chk("cyc_in_ready", in_ready, mq.size() != DEPTH);
            chk("cyc_busy", busy, (m_hs != 0) || m_strobe || (mq.size() != 0));
            chk("cyc_err", timeout_err, m_err);
        end
        if (sync_din_en) begin
            seen.push_back(sync_din);
            st.push_back(cyc);
        end
    end

    task automatic push_word(input logic [DW-1:0] w);
        int b;
        @(negedge clk);
        in_valid = 1'b1;
        in_data = w;
        b = 0;
        while (!in_ready && b < 200) begin
            @(negedge clk);
            b++;
        end
        chk("push_accept", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_strobe(input int bound);
        int b;
        b = 0;
        @(negedge clk);
        while (!sync_din_en && b < bound) begin
            @(negedge clk);
            b++;
        end
        chk("strobe_seen", sync_din_en, 1);
    endtask

    task automatic wait_idle(input int bound);
        int b;
        b = 0;
        @(negedge clk);
        while (busy && b < bound) begin
            @(negedge clk);
            b++;
        end
        chk("idle_reached", busy, 0);
    endtask

    logic [DW-1:0] exp_w;

    initial begin
        #1 rst = 1'b1;
        #1 chk_on = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;

        // Reset values
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_din", sync_din, 0);
        chk("rst_en", sync_din_en, 0);
        chk("rst_level", level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", timeout_err, 0);

        // Single word: strobe in the cycle after push edge + 1
        in_valid = 1'b1;
        in_data = 32'hDEADBEEF;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("single_level1", level, 1);
        chk("single_en_early", sync_din_en, 0);
        @(negedge clk);
        chk("single_en", sync_din_en, 1);
        chk("single_din", sync_din, 32'hDEADBEEF);
        chk("single_level0", level, 0);
        @(negedge clk);
        chk("single_en_drop", sync_din_en, 0);
        chk("single_din_hold", sync_din, 32'hDEADBEEF);
        wait_idle(50);

        // Handshake pacing
        seen.delete();
        st.delete();
        push_word(32'hA000_0001);
        push_word(32'hA000_0002);
        push_word(32'hA000_0003);
        wait_idle(100);
        chk("pace_count", seen.size(), 3);
        if (seen.size() == 3) begin
            chk("pace_w0", seen[0], 32'hA000_0001);
            chk("pace_w1", seen[1], 32'hA000_0002);
            chk("pace_w2", seen[2], 32'hA000_0003);
            chk("pace_gap01", st[1] - st[0] >= 8, 1);
            chk("pace_gap12", st[2] - st[1] >= 8, 1);
        end

        // Full FIFO with srdy held low
        @(negedge clk);
        hs_auto = 1'b0;
        sync_srdy = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = 32'hB000_0000 + i;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("full_level", level, 4);
        chk("full_in_ready", in_ready, 0);
        seen.delete();
        hs_auto = 1'b1;
        rt = 0;
        sync_srdy = 1'b1;
        wait_strobe(20);
        chk("full_first_pop_ready", in_ready, 1);
        chk("full_first_pop_level", level, 3);
        wait_idle(200);
        chk("full_count", seen.size(), 4);
        for (int i = 0; i < 4; i++) begin
            exp_w = 32'hB000_0000 + i;
            if (i < seen.size()) chk("full_order", seen[i], exp_w);
        end

        // Wrap-around stream with random producer gaps
        seen.delete();
        for (int i = 0; i < 10; i++) begin
            push_word(32'hC000_0000 + i * 32'h111);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle(400);
        chk("wrap_count", seen.size(), 10);
        for (int i = 0; i < 10; i++) begin
            exp_w = 32'hC000_0000 + i * 32'h111;
            if (i < seen.size()) chk("wrap_order", seen[i], exp_w);
        end

        // Timeout: srdy never drops after the strobe
        @(negedge clk);
        hs_auto = 1'b0;
        sync_srdy = 1'b1;
        push_word(32'hE000_0001);
        wait_strobe(20);
        repeat (TO) @(negedge clk);
        chk("to_not_yet", timeout_err, 0);
        @(negedge clk);
        chk("to_set", timeout_err, 1);
        chk("to_idle", busy, 0);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("to_cleared", timeout_err, 0);
        push_word(32'hE000_0002);
        wait_strobe(20);
        chk("to_second_din", sync_din, 32'hE000_0002);
        repeat (TO) @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("to_set_wins", timeout_err, 1);

        // Reset during WAIT_HIGH with two words buffered
        in_valid = 1'b1;
        in_data = 32'hF000_0000;
        @(negedge clk);
        in_data = 32'hF000_0001;
        @(negedge clk);
        in_data = 32'hF000_0002;
        @(negedge clk);
        in_valid = 1'b0;
        sync_srdy = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_level", level, 2);
        chk("mid_busy", busy, 1);
        chk("mid_din", sync_din, 32'hF000_0000);
        #2;
        rst = 1'b1;
        rt = 0;
        sync_srdy = 1'b1;
        @(negedge clk);
        chk("rst_mid_level", level, 0);
        chk("rst_mid_en", sync_din_en, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_err", timeout_err, 0);
        chk("rst_mid_din", sync_din, 0);
        #2;
        rst = 1'b0;
        hs_auto = 1'b1;
        push_word(32'h1234_5678);
        wait_strobe(20);
        chk("post_rst_din", sync_din, 32'h1234_5678);
        wait_idle(50);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
